led_pwm_array: RTL and testbench
================================

// Module: led_pwm_array
// PURPOSE
//  Parametrised N-channel RGB LED PWM engine; successor to the fixed 3-LED static driver.
//  Adds per-LED STATIC/BLINK/BREATHE modes, glitch-free frame-aligned updates and a config-error flag.
//  Sits between the register block (write-only config port) and the RGB LED pins.
// PARAMETERS
//  NUM_LEDS     3   number of RGB LEDs (1..16); IDXW = max(1,$clog2(NUM_LEDS))
//  PWM_BITS     8   colour/duty resolution; frame = 2^PWM_BITS-1 PWM steps
//  PWM_DIV      4   clk cycles per PWM step (>=1)
//  CLK_FRQ_MHZ  26  clock frequency; timing tick = CLK_FRQ_MHZ*1000 clks (1 ms)
//  ACTIVE_LOW   0   1: LED outputs inverted (on = 0)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          reset, asynchronous, active-low
//  cfg_wr       in   1          1-cycle config write strobe
//  cfg_led      in   IDXW       target LED index
//  cfg_field    in   3          0 duty,1 red,2 green,3 blue,4 mode,5 blink times,6 breathe step
//  cfg_data     in   16         field value (LSB-aligned, truncated to field width)
//  cfg_err      out  1          1-cycle pulse on rejected/odd write
//  frame_start  out  1          1-cycle pulse when shadow config is applied
//  led_red      out  NUM_LEDS   red PWM outputs
//  led_green    out  NUM_LEDS   green PWM outputs
//  led_blue     out  NUM_LEDS   blue PWM outputs
// BEHAVIOUR
//  Reset (rst=0, async): all shadow/active regs 0, mode STATIC, counters 0, cfg_err=frame_start=0,
//   LED outputs inactive (0, or 1 if ACTIVE_LOW) immediately without a clock edge.
//  PWM: prescaler 0..PWM_DIV-1; pwm_cnt steps 0..2^PWM_BITS-2 then wraps to 0.
//   Wrap cycle = frame boundary: frame_start=1, shadow -> active copy for every LED.
//  Writes: cfg_wr latches into shadow only, next clk. Visible on outputs from the next frame_start.
//   Write in same cycle as frame_start: the apply uses the pre-write shadow; the write lands next frame.
//   cfg_led>=NUM_LEDS or cfg_field==7: write dropped, cfg_err=1 next clk.
//   mode write of 3: stored as STATIC, cfg_err=1.
//  Field 5: on_ticks=cfg_data[7:0], off_ticks=cfg_data[15:8]. Field 6: step_ticks=cfg_data[7:0] (0 treated as 1).
//  Level: per-LED lvl (PWM_BITS) = duty in STATIC/BLINK, ramp value in BREATHE.
//  Effective colour: eff = (colour*(lvl+1)) >> PWM_BITS (full 2*PWM_BITS+1 product, no overflow).
//   Channel on iff pwm_cnt < eff: eff=0 always off, eff=2^PWM_BITS-1 always on.
//  Tick: 1 ms strobe from CLK_FRQ_MHZ*1000-1 counter; runs independent of frames.
//  BLINK FSM per LED: ON --on_ticks ticks--> OFF --off_ticks ticks--> ON. OFF forces eff=0.
//   on_ticks=0: permanently OFF; off_ticks=0 (on>0): permanently ON; both 0: OFF.
//  BREATHE FSM per LED: UP: lvl+=1 every step_ticks ticks until lvl==duty -> DOWN;
//   DOWN: lvl-=1 until 0 -> UP. duty=0: lvl stays 0.
//   Duty lowered below lvl on apply: lvl clamps to duty, state DOWN.
//  Mode change applied at frame_start: FSM restarts (BLINK in ON, tick cnt 0; BREATHE in UP, lvl 0).
//  Outputs registered: 1 clk after pwm_cnt/eff compare, polarity per ACTIVE_LOW.
// TESTING
//  1 Reset, LED0 red=255 duty=255 -> after next frame_start led_red[0]=1 constantly, green/blue 0.
//  2 LED1 red=128 duty=255, PWM_DIV=4 -> eff=128; led_red[1] high 512 of 1020 clks per frame.
//  3 LED2 green=255 duty=127 -> eff=127; duty=0 -> led_green[2] stuck 0; write in frame_start cycle
//     takes effect one frame later.
//  4 LED0 mode=BLINK on=2 off=3 -> 2 ms on / 3 ms off period 5 ms; on=0 -> always off.
//  5 LED1 BREATHE duty=4 step=1 -> lvl 0,1,2,3,4,3,2,1,0 at 1 ms steps; eff follows formula.
//  6 cfg_led=3 (NUM_LEDS=3) or field=7 -> cfg_err pulse, state unchanged; rst low mid-frame
//     -> outputs inactive asynchronously; ACTIVE_LOW=1 inverts all checks.

Source files
------------

// File: rtl/led_pwm_array.sv
// N-channel RGB LED PWM engine with per-LED static, blink and breathe modes.
// Config writes land in a shadow bank that is copied to the active bank on every frame boundary.
module led_pwm_array #(
   parameter int NUM_LEDS    = 3,
   parameter int PWM_BITS    = 8,
   parameter int PWM_DIV     = 4,
   parameter int CLK_FRQ_MHZ = 26,
   parameter bit ACTIVE_LOW  = 1'b0,
   localparam int IDXW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_wr,
   input  logic [IDXW-1:0]     cfg_led,
   input  logic [2:0]          cfg_field,
   input  logic [15:0]         cfg_data,
   output logic                cfg_err,
   output logic                frame_start,
   output logic [NUM_LEDS-1:0] led_red,
   output logic [NUM_LEDS-1:0] led_green,
   output logic [NUM_LEDS-1:0] led_blue
);

   localparam int PSW       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int TICK_CLKS = CLK_FRQ_MHZ * 1000;
   localparam int TKW       = $clog2(TICK_CLKS);

   localparam logic [PSW-1:0]      PRESC_TOP = PSW'(PWM_DIV - 1);
   localparam logic [PWM_BITS-1:0] CNT_TOP   = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [TKW-1:0]      TICK_TOP  = TKW'(TICK_CLKS - 1);

   localparam logic [1:0] MODE_STATIC  = 2'd0;
   localparam logic [1:0] MODE_BLINK   = 2'd1;
   localparam logic [1:0] MODE_BREATHE = 2'd2;

   typedef enum logic [1:0] {ST_ON, ST_OFF, ST_UP, ST_DOWN} fsm_t;

   function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] colour,
                                                 input logic [PWM_BITS-1:0] level);
      logic [2*PWM_BITS:0] prod;
      prod = {{(PWM_BITS+1){1'b0}}, colour} * ({{(PWM_BITS+1){1'b0}}, level} + 1'b1);
      return PWM_BITS'(prod >> PWM_BITS);
   endfunction

   logic [PSW-1:0]      presc_reg;
   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [TKW-1:0]      tick_cnt_reg;
   logic                step, wrap, tick;
   logic                led_bad, cfg_bad, cfg_err_reg;
   logic [NUM_LEDS-1:0] red_on, green_on, blue_on;

   assign step = (presc_reg == PRESC_TOP);
   assign wrap = step && (pwm_cnt_reg == CNT_TOP);
   assign tick = (tick_cnt_reg == TICK_TOP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg    <= '0;
         pwm_cnt_reg  <= '0;
         tick_cnt_reg <= '0;
      end else begin
         presc_reg    <= step ? '0 : presc_reg + 1'b1;
         tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
         if (step)
            pwm_cnt_reg <= wrap ? '0 : pwm_cnt_reg + 1'b1;
      end
   end

   assign frame_start = wrap;

   // A mode value of 3 is still written (as STATIC) but flagged.
   assign led_bad = (32'(cfg_led) >= 32'(NUM_LEDS));
   assign cfg_bad = cfg_wr && (led_bad || (cfg_field == 3'd7) ||
                               ((cfg_field == 3'd4) && (cfg_data[1:0] == 2'd3)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cfg_err_reg <= 1'b0;
      else      cfg_err_reg <= cfg_bad;
   end

   assign cfg_err = cfg_err_reg;

   for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic [PWM_BITS-1:0] sh_duty_reg, sh_red_reg, sh_green_reg, sh_blue_reg;
      logic [PWM_BITS-1:0] act_duty_reg, act_red_reg, act_green_reg, act_blue_reg;
      logic [1:0]          sh_mode_reg, act_mode_reg;
      logic [7:0]          sh_on_reg, sh_off_reg, sh_step_reg;
      logic [7:0]          act_on_reg, act_off_reg, act_step_reg;
      fsm_t                state_reg, state_next;
      logic [7:0]          cnt_reg, cnt_next;
      logic [PWM_BITS-1:0] lvl_reg, lvl_next;
      logic [PWM_BITS-1:0] lvl;
      logic [7:0]          step_eff;
      logic                sel, lit;

      assign sel = cfg_wr && (cfg_led == IDXW'(gi)) && (cfg_field != 3'd7);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sh_duty_reg  <= '0;
            sh_red_reg   <= '0;
            sh_green_reg <= '0;
            sh_blue_reg  <= '0;
            sh_mode_reg  <= MODE_STATIC;
            sh_on_reg    <= '0;
            sh_off_reg   <= '0;
            sh_step_reg  <= '0;
         end else if (sel) begin
            case (cfg_field)
               3'd0: sh_duty_reg  <= cfg_data[PWM_BITS-1:0];
               3'd1: sh_red_reg   <= cfg_data[PWM_BITS-1:0];
               3'd2: sh_green_reg <= cfg_data[PWM_BITS-1:0];
               3'd3: sh_blue_reg  <= cfg_data[PWM_BITS-1:0];
               3'd4: sh_mode_reg  <= (cfg_data[1:0] == 2'd3) ? MODE_STATIC : cfg_data[1:0];
               3'd5: begin
                  sh_on_reg  <= cfg_data[7:0];
                  sh_off_reg <= cfg_data[15:8];
               end
               3'd6: sh_step_reg <= cfg_data[7:0];
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            act_duty_reg  <= '0;
            act_red_reg   <= '0;
            act_green_reg <= '0;
            act_blue_reg  <= '0;
            act_mode_reg  <= MODE_STATIC;
            act_on_reg    <= '0;
            act_off_reg   <= '0;
            act_step_reg  <= '0;
         end else if (wrap) begin
            act_duty_reg  <= sh_duty_reg;
            act_red_reg   <= sh_red_reg;
            act_green_reg <= sh_green_reg;
            act_blue_reg  <= sh_blue_reg;
            act_mode_reg  <= sh_mode_reg;
            act_on_reg    <= sh_on_reg;
            act_off_reg   <= sh_off_reg;
            act_step_reg  <= sh_step_reg;
         end
      end

      assign step_eff = (act_step_reg == 8'd0) ? 8'd1 : act_step_reg;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_reg <= ST_ON;
            cnt_reg   <= '0;
            lvl_reg   <= '0;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            lvl_reg   <= lvl_next;
         end
      end

      // Restart and clamp happen on the apply edge and take priority over a coincident tick.
      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         lvl_next   = lvl_reg;
         if (wrap && (sh_mode_reg != act_mode_reg)) begin
            state_next = (sh_mode_reg == MODE_BREATHE) ? ST_UP : ST_ON;
            cnt_next   = '0;
            lvl_next   = '0;
         end else if (wrap && (act_mode_reg == MODE_BREATHE) && (sh_duty_reg < lvl_reg)) begin
            state_next = ST_DOWN;
            cnt_next   = '0;
            lvl_next   = sh_duty_reg;
         end else if (tick) begin
            case (act_mode_reg)
               MODE_BLINK: begin
                  if (state_reg == ST_ON) begin
                     if (cnt_reg + 8'd1 >= act_on_reg) begin
                        state_next = ST_OFF;
                        cnt_next   = '0;
                     end else begin
                        cnt_next = cnt_reg + 8'd1;
                     end
                  end else begin
                     if (cnt_reg + 8'd1 >= act_off_reg) begin
                        state_next = ST_ON;
                        cnt_next   = '0;
                     end else begin
                        cnt_next = cnt_reg + 8'd1;
                     end
                  end
               end
               MODE_BREATHE: begin
                  if (cnt_reg + 8'd1 >= step_eff) begin
                     cnt_next = '0;
                     if (act_duty_reg == '0) begin
                        state_next = ST_UP;
                        lvl_next   = '0;
                     end else if (state_reg == ST_DOWN) begin
                        lvl_next = lvl_reg - 1'b1;
                        if (lvl_reg == PWM_BITS'(1))
                           state_next = ST_UP;
                     end else begin
                        lvl_next = lvl_reg + 1'b1;
                        if (lvl_reg + 1'b1 >= act_duty_reg)
                           state_next = ST_DOWN;
                     end
                  end else begin
                     cnt_next = cnt_reg + 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end

      assign lvl = (act_mode_reg == MODE_BREATHE) ? lvl_reg : act_duty_reg;
      assign lit = (act_mode_reg != MODE_BLINK) ||
                   ((act_on_reg != 8'd0) && ((act_off_reg == 8'd0) || (state_reg == ST_ON)));

      assign red_on[gi]   = lit && (pwm_cnt_reg < scale(act_red_reg, lvl));
      assign green_on[gi] = lit && (pwm_cnt_reg < scale(act_green_reg, lvl));
      assign blue_on[gi]  = lit && (pwm_cnt_reg < scale(act_blue_reg, lvl));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_red   <= {NUM_LEDS{ACTIVE_LOW}};
         led_green <= {NUM_LEDS{ACTIVE_LOW}};
         led_blue  <= {NUM_LEDS{ACTIVE_LOW}};
      end else begin
         led_red   <= red_on ^ {NUM_LEDS{ACTIVE_LOW}};
         led_green <= green_on ^ {NUM_LEDS{ACTIVE_LOW}};
         led_blue  <= blue_on ^ {NUM_LEDS{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_led_pwm_array.sv
// Bench for led_pwm_array: directed and random config, every cycle checked against a time-based model.
// A second instance with inverted outputs shares all inputs.
module tb_led_pwm_array;

   localparam int NUM_LEDS    = 3;
   localparam int PWM_BITS    = 8;
   localparam int PWM_DIV     = 4;
   localparam int CLK_FRQ_MHZ = 1;
   localparam int IDXW        = 2;
   localparam int STEPS       = (1 << PWM_BITS) - 1;
   localparam int FRAME       = STEPS * PWM_DIV;
   localparam int TICK        = CLK_FRQ_MHZ * 1000;
   localparam int LEVELS      = 1 << PWM_BITS;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                cfg_wr = 1'b0;
   logic [IDXW-1:0]     cfg_led = '0;
   logic [2:0]          cfg_field = '0;
   logic [15:0]         cfg_data = '0;
   logic                cfg_err, frame_start, cfg_err_al, frame_start_al;
   logic [NUM_LEDS-1:0] led_red, led_green, led_blue;
   logic [NUM_LEDS-1:0] led_red_al, led_green_al, led_blue_al;

   always #5 clk = ~clk;

   led_pwm_array #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS), .PWM_DIV(PWM_DIV),
                   .CLK_FRQ_MHZ(CLK_FRQ_MHZ), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_led(cfg_led), .cfg_field(cfg_field),
      .cfg_data(cfg_data), .cfg_err(cfg_err), .frame_start(frame_start),
      .led_red(led_red), .led_green(led_green), .led_blue(led_blue));

   led_pwm_array #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS), .PWM_DIV(PWM_DIV),
                   .CLK_FRQ_MHZ(CLK_FRQ_MHZ), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_led(cfg_led), .cfg_field(cfg_field),
      .cfg_data(cfg_data), .cfg_err(cfg_err_al), .frame_start(frame_start_al),
      .led_red(led_red_al), .led_green(led_green_al), .led_blue(led_blue_al));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model config: index 0 duty, 1 red, 2 green, 3 blue, 4 mode, 5 on, 6 step, 7 off.
   int sh[NUM_LEDS][8];
   int act[NUM_LEDS][8];
   int restart[NUM_LEDS];
   logic [3*NUM_LEDS-1:0] led_exp;
   logic                  err_exp;

   int wq_led[$];
   int wq_field[$];
   int wq_data[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM_LEDS; i++) begin
         for (int j = 0; j < 8; j++) begin
            sh[i][j]  = 0;
            act[i][j] = 0;
         end
         restart[i] = -1;
      end
      led_exp = '0;
      err_exp = 1'b0;
      cyc     = 0;
   endfunction

   // Level from the mode rules: blink phase and breathe triangle follow ticks elapsed since restart.
   function automatic int model_eff(input int i, input int colour, input int c);
      int k, lvl, st, s, d, ph;
      bit lit;
      k   = c / TICK - (restart[i] + 1) / TICK;
      lvl = act[i][0];
      lit = 1'b1;
      if (act[i][4] == 1) begin
         lit = (act[i][5] != 0) && ((act[i][7] == 0) || ((k % (act[i][5] + act[i][7])) < act[i][5]));
      end else if (act[i][4] == 2) begin
         st = (act[i][6] == 0) ? 1 : act[i][6];
         s  = k / st;
         d  = act[i][0];
         if (d == 0) lvl = 0;
         else begin
            ph  = s % (2 * d);
            lvl = (ph <= d) ? ph : 2 * d - ph;
         end
      end
      return lit ? (colour * (lvl + 1)) / LEVELS : 0;
   endfunction

   function automatic void model_write(input int led, input int field, input int data);
      int m;
      case (field)
         0, 1, 2, 3: sh[led][field] = data & 255;
         4: begin
            m = data & 3;
            sh[led][4] = (m == 3) ? 0 : m;
         end
         5: begin
            sh[led][5] = data & 255;
            sh[led][7] = (data >> 8) & 255;
         end
         6: sh[led][6] = data & 255;
         default: ;
      endcase
   endfunction

   task automatic run_cycle(input bit wr, input int led, input int field, input int data);
      logic [3*NUM_LEDS+1:0] exp_v;
      logic [3*NUM_LEDS-1:0] nxt;
      logic                  fs_now;
      fs_now = ((cyc % FRAME) == FRAME - 1);
      exp_v  = {fs_now, err_exp, led_exp};
      check("out", 32'({frame_start, cfg_err, led_red, led_green, led_blue}), 32'(exp_v));
      check("out_al", 32'({frame_start_al, cfg_err_al, led_red_al, led_green_al, led_blue_al}),
            32'({fs_now, err_exp, ~led_exp}));

      cfg_wr    = wr;
      cfg_led   = IDXW'(led);
      cfg_field = 3'(field);
      cfg_data  = 16'(data);
      if (wr) $display("wr cyc=%0d led=%0d field=%0d data=%h", cyc, led, field, 16'(data));

      nxt = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if ((cyc / PWM_DIV) % STEPS < model_eff(i, act[i][1], cyc)) nxt[2*NUM_LEDS+i] = 1'b1;
         if ((cyc / PWM_DIV) % STEPS < model_eff(i, act[i][2], cyc)) nxt[NUM_LEDS+i]   = 1'b1;
         if ((cyc / PWM_DIV) % STEPS < model_eff(i, act[i][3], cyc)) nxt[i]            = 1'b1;
      end
      led_exp = nxt;
      err_exp = wr && ((led >= NUM_LEDS) || (field == 7) || ((field == 4) && ((data & 3) == 3)));

      // The apply sees the shadow as it was before this cycle's write.
      if (fs_now) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (sh[i][4] != act[i][4]) restart[i] = cyc;
            for (int j = 0; j < 8; j++) act[i][j] = sh[i][j];
         end
      end
      if (wr && (led < NUM_LEDS) && (field != 7)) model_write(led, field, data);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      check("rst_async", 32'({frame_start, cfg_err, led_red, led_green, led_blue}), 32'(0));
      check("rst_async_al", 32'({frame_start_al, cfg_err_al, led_red_al, led_green_al, led_blue_al}),
            32'(11'h1ff));
      @(negedge clk);
      @(negedge clk);
      cfg_wr = 1'b0;
      rst    = 1'b1;
      model_reset();
   endtask

   task automatic push_wr(input int led, input int field, input int data);
      wq_led.push_back(led);
      wq_field.push_back(field);
      wq_data.push_back(data);
   endtask

   // fl < 0 disables the write placed exactly on the second frame_start cycle.
   task automatic run_trial(input int ncyc, input bit rnd_mid, input int fl, input int ff, input int fd);
      int l, f, d;
      for (int n = 0; n < ncyc; n++) begin
         if (wq_led.size() > 0) begin
            l = wq_led.pop_front();
            f = wq_field.pop_front();
            d = wq_data.pop_front();
            run_cycle(1'b1, l, f, d);
         end else if ((n == 2 * FRAME - 1) && (fl >= 0)) begin
            run_cycle(1'b1, fl, ff, fd);
         end else if (rnd_mid && ($urandom_range(0, 149) == 0)) begin
            l = $urandom_range(0, NUM_LEDS - 1);
            f = $urandom_range(0, 4);
            d = $urandom_range(0, 65535);
            if ((f == 0) && ((sh[l][4] == 2) || (act[l][4] == 2))) f = 1;
            if (f == 4) begin
               if ($urandom_range(0, 1) == 1) begin
                  l = NUM_LEDS;
                  f = $urandom_range(0, 6);
               end else begin
                  f = 7;
               end
            end
            run_cycle(1'b1, l, f, d);
         end else begin
            run_cycle(1'b0, 0, 0, 0);
         end
      end
   endtask

   function automatic int rnd_colour();
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) return 0;
      if (sel == 1) return 255;
      return $urandom_range(0, 255);
   endfunction

   initial begin
      int m;
      @(negedge clk);
      do_reset();

      // Static levels: full on, half-scaled red, duty 127 then duty 0 written on a frame_start cycle.
      push_wr(0, 1, 255);  push_wr(0, 0, 255);
      push_wr(1, 1, 128);  push_wr(1, 0, 255);
      push_wr(2, 2, 255);  push_wr(2, 0, 127);
      run_trial(4 * FRAME + 10, 1'b0, 2, 0, 0);
      do_reset();

      // Blink 2/3 ms, breathe duty 4 step 1, blink with on=0, plus rejected writes.
      push_wr(0, 1, 255);  push_wr(0, 0, 255);  push_wr(0, 5, 16'h0302);
      push_wr(0, 4, 3);    push_wr(0, 4, 1);
      push_wr(1, 3, 255);  push_wr(1, 0, 4);    push_wr(1, 6, 1);  push_wr(1, 4, 2);
      push_wr(2, 2, 255);  push_wr(2, 0, 255);  push_wr(2, 5, 16'h0300); push_wr(2, 4, 1);
      push_wr(3, 0, 5);    push_wr(1, 7, 0);
      run_trial(12000, 1'b0, 0, 2, 16'h0080);
      do_reset();

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < NUM_LEDS; i++) begin
            m = $urandom_range(0, 3);
            push_wr(i, 1, ($urandom_range(0, 255) << 8) | rnd_colour());
            push_wr(i, 2, ($urandom_range(0, 255) << 8) | rnd_colour());
            push_wr(i, 3, ($urandom_range(0, 255) << 8) | rnd_colour());
            push_wr(i, 0, (m == 2) ? $urandom_range(0, 6) : $urandom_range(0, 255));
            push_wr(i, 5, ($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
            push_wr(i, 6, $urandom_range(0, 2));
            push_wr(i, 4, ($urandom_range(0, 16383) << 2) | m);
         end
         push_wr(NUM_LEDS, $urandom_range(0, 6), $urandom_range(0, 65535));
         run_trial(10 * FRAME, 1'b1, $urandom_range(0, NUM_LEDS - 1), $urandom_range(1, 3),
                   $urandom_range(0, 65535));
         do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "simulation time limit reached");
   end

endmodule
